// File: rtl/rvh_l1d_wb_arb.sv
`default_nettype none
// ============================================================================
// Module  : rvh_l1d_wb_arb
// Brief   : Shares the L2 AW/W/B write channel between N_REQ L1D eviction
//           queues. AW is granted round-robin, W follows AW order, and B is
//           routed back by master ID. Optional macro
//           RVH_L1D_WB_ARB_BRESP_CHK_EN enables the sticky response error flag.
// Rev     : 1.0
// ============================================================================
module rvh_l1d_wb_arb #(
    parameter int N_REQ           = 2,
    parameter int ORDER_DEPTH     = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_awvalid_i,
    input  logic [N_REQ*77-1:0]  req_aw_i,
    output logic [N_REQ-1:0]     req_awready_o,
    input  logic [N_REQ-1:0]     req_wvalid_i,
    input  logic [N_REQ*73-1:0]  req_w_i,
    output logic [N_REQ-1:0]     req_wready_o,
    output logic [N_REQ-1:0]     req_bvalid_o,
    output logic [9:0]           req_b_o,
    input  logic [N_REQ-1:0]     req_bready_i,
    output logic                 l2_awvalid_o,
    input  logic                 l2_awready_i,
    output logic [76:0]          l2_aw_o,
    output logic                 l2_wvalid_o,
    input  logic                 l2_wready_i,
    output logic [72:0]          l2_w_o,
    input  logic                 l2_bvalid_i,
    output logic                 l2_bready_o,
    input  logic [9:0]           l2_b_i,
    output logic                 err_o
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int OW = $clog2(ORDER_DEPTH);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [IW-1:0] r_rr_ptr;
    logic          r_aw_lock_vld;
    logic [IW-1:0] r_aw_lock_idx;
    logic [IW-1:0] r_fifo [ORDER_DEPTH];
    logic [OW-1:0] r_rd_ptr;
    logic [OW-1:0] r_wr_ptr;
    logic [OW:0]   r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] w_outstanding_nxt;

    logic          w_hi_any, w_lo_any;
    logic [IW-1:0] w_hi_sel, w_lo_sel;
    logic [IW-1:0] w_grant_idx;
    logic          w_elig, w_empty;
    logic [IW-1:0] w_head;
    logic          w_aw_hs, w_pop, w_b_hs, w_b_in;
    logic [2:0]    w_b_tgt;

    // hi: lowest requester at/after the pointer; lo: lowest overall (wrap case)
    always_comb begin
        w_hi_any = 1'b0;
        w_hi_sel = '0;
        w_lo_any = 1'b0;
        w_lo_sel = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_awvalid_i[i]) begin
                w_lo_any = 1'b1;
                w_lo_sel = IW'(i);
                if (IW'(i) >= r_rr_ptr) begin
                    w_hi_any = 1'b1;
                    w_hi_sel = IW'(i);
                end
            end
        end
    end

    assign w_grant_idx  = r_aw_lock_vld ? r_aw_lock_idx : (w_hi_any ? w_hi_sel : w_lo_sel);
    assign w_elig       = (r_count != (OW+1)'(ORDER_DEPTH)) &&
                          (r_outstanding < CW'(MAX_OUTSTANDING));
    assign l2_awvalid_o = w_elig & (r_aw_lock_vld | w_lo_any);
    assign w_aw_hs      = l2_awvalid_o & l2_awready_i;

    assign w_empty = (r_count == '0);
    assign w_head  = r_fifo[r_rd_ptr];

    assign w_b_tgt = l2_b_i[8:6];
    assign w_b_in  = ({1'b0, w_b_tgt} < 4'(N_REQ));
    assign req_b_o = l2_b_i;

    always_comb begin
        l2_aw_o       = '0;
        l2_w_o        = '0;
        l2_wvalid_o   = 1'b0;
        l2_bready_o   = 1'b1;
        req_awready_o = '0;
        req_wready_o  = '0;
        req_bvalid_o  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant_idx == IW'(i)) begin
                l2_aw_o          = req_aw_i[i*77 +: 77];
                req_awready_o[i] = w_aw_hs;
            end
            if (w_head == IW'(i)) begin
                l2_w_o          = req_w_i[i*73 +: 73];
                l2_wvalid_o     = req_wvalid_i[i] & ~w_empty;
                req_wready_o[i] = l2_wready_i & ~w_empty;
            end
            if (w_b_tgt == 3'(i)) begin
                l2_bready_o     = req_bready_i[i];
                req_bvalid_o[i] = l2_bvalid_i;
            end
        end
    end

    assign w_pop  = l2_wvalid_o & l2_wready_i & l2_w_o[8];
    assign w_b_hs = l2_bvalid_i & l2_bready_o;

    // Saturating count; a simultaneous AW and B cancel out
    always_comb begin
        w_outstanding_nxt = r_outstanding;
        if (w_aw_hs && !w_b_hs)
            w_outstanding_nxt = r_outstanding + CW'(1);
        else if (!w_aw_hs && w_b_hs && (r_outstanding != '0))
            w_outstanding_nxt = r_outstanding - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr_ptr      <= '0;
            r_aw_lock_vld <= 1'b0;
            r_aw_lock_idx <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_aw_hs) begin
                r_aw_lock_vld <= 1'b0;
                r_rr_ptr      <= (w_grant_idx == IW'(N_REQ - 1)) ? '0 : w_grant_idx + IW'(1);
            end else if (l2_awvalid_o) begin
                r_aw_lock_vld <= 1'b1;
                r_aw_lock_idx <= w_grant_idx;
            end
            if (w_aw_hs)
                r_wr_ptr <= r_wr_ptr + OW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + OW'(1);
            if (w_aw_hs && !w_pop)
                r_count <= r_count + (OW+1)'(1);
            else if (!w_aw_hs && w_pop)
                r_count <= r_count - (OW+1)'(1);
            r_outstanding <= w_outstanding_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_aw_hs)
            r_fifo[r_wr_ptr] <= w_grant_idx;
    end

`ifdef RVH_L1D_WB_ARB_BRESP_CHK_EN
    logic r_err;
    logic w_underflow;

    assign w_underflow = w_b_hs & ~w_aw_hs & (r_outstanding == '0);

    always_ff @(posedge clk) begin
        if (!rst)
            r_err <= 1'b0;
        else if (w_b_hs && ((l2_b_i[1:0] != 2'b00) || !w_b_in || w_underflow))
            r_err <= 1'b1;
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rvh_l1d_wb_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_rvh_l1d_wb_arb
// Brief   : Randomized bench for rvh_l1d_wb_arb against a queue-based model.
// Rev     : 1.0
// ============================================================================
module tb_rvh_l1d_wb_arb;

    localparam int N = 3;
    localparam int D = 4;
    localparam int M = 8;
    localparam int NCYC = 4000;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_awvalid, req_awready, req_wvalid, req_wready;
    logic [N-1:0]     req_bvalid, req_bready;
    logic [N*77-1:0]  req_aw;
    logic [N*73-1:0]  req_w;
    logic [9:0]       req_b;
    logic             l2_awvalid, l2_awready, l2_wvalid, l2_wready;
    logic             l2_bvalid, l2_bready, err;
    logic [76:0]      l2_aw;
    logic [72:0]      l2_w;
    logic [9:0]       l2_b;

    rvh_l1d_wb_arb #(.N_REQ(N), .ORDER_DEPTH(D), .MAX_OUTSTANDING(M)) dut (
        .clk(clk), .rst(rst),
        .req_awvalid_i(req_awvalid), .req_aw_i(req_aw), .req_awready_o(req_awready),
        .req_wvalid_i(req_wvalid), .req_w_i(req_w), .req_wready_o(req_wready),
        .req_bvalid_o(req_bvalid), .req_b_o(req_b), .req_bready_i(req_bready),
        .l2_awvalid_o(l2_awvalid), .l2_awready_i(l2_awready), .l2_aw_o(l2_aw),
        .l2_wvalid_o(l2_wvalid), .l2_wready_i(l2_wready), .l2_w_o(l2_w),
        .l2_bvalid_i(l2_bvalid), .l2_bready_o(l2_bready), .l2_b_i(l2_b),
        .err_o(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Requester-side traffic and model state
    logic [76:0] aw_q [N][$];
    logic [72:0] w_q  [N][$];
    bit          aw_on [N];
    logic [7:0]  bq [$];
    bit          b_on, b_bogus;
    logic [9:0]  b_cur;
    int          order [$];
    int          rr, outst, lock_idx;
    bit          lock_vld, err_m;
    int          wr_pct, b_pct;

    task automatic gen_txn(input int i);
        int beats;
        logic [3:0] tid;
        beats = $urandom_range(1, 8);
        tid   = 4'($urandom_range(0, 15));
        aw_q[i].push_back({4'(i), tid, 56'({$urandom, $urandom}), 8'(beats - 1), 3'd3, 2'b01});
        for (int b = 0; b < beats; b++)
            w_q[i].push_back({64'({$urandom, $urandom}), (b == beats - 1), 4'(i), tid});
    endtask

    task automatic drive_idle();
        req_awvalid = '0; req_aw = '0; req_wvalid = '0; req_w = '0; req_bready = '0;
        l2_awready = 1'b1; l2_wready = 1'b1; l2_bvalid = 1'b0; l2_b = '0;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            aw_q[i].delete(); w_q[i].delete(); aw_on[i] = 0;
        end
        bq.delete(); order.delete();
        b_on = 0; b_bogus = 0; b_cur = '0;
        rr = 0; outst = 0; lock_vld = 0; lock_idx = 0; err_m = 0;
    endtask

    task automatic reset_checks();
        chk("rst_awvalid", l2_awvalid, 0);
        chk("rst_awready", req_awready, 0);
        chk("rst_wvalid", l2_wvalid, 0);
        chk("rst_wready", req_wready, 0);
        chk("rst_bvalid", req_bvalid, 0);
        chk("rst_err", err, 0);
    endtask

    task automatic drive_random(input int cyc);
        for (int i = 0; i < N; i++) begin
            if (aw_q[i].size() < 2 && $urandom_range(0, 99) < 30) gen_txn(i);
            if (!aw_on[i] && aw_q[i].size() > 0 && $urandom_range(0, 1) == 1) aw_on[i] = 1;
            req_awvalid[i]     = aw_on[i];
            req_aw[i*77 +: 77] = (aw_q[i].size() > 0) ? aw_q[i][0] : 77'(0);
            req_wvalid[i]      = (w_q[i].size() > 0) && ($urandom_range(0, 99) < 75);
            req_w[i*73 +: 73]  = (w_q[i].size() > 0) ? w_q[i][0] : 73'(0);
            req_bready[i]      = ($urandom_range(0, 99) < 70);
        end
        wr_pct = (cyc >= 500 && cyc < 900) ? 5 : 70;
        b_pct  = (cyc >= 1200 && cyc < 1600) ? 2 : 50;
        l2_awready = ($urandom_range(0, 99) < 60);
        l2_wready  = ($urandom_range(0, 99) < wr_pct);
        if (!b_on) begin
            if ($urandom_range(0, 99) < 3) begin
                b_cur = {1'b0, 3'($urandom_range(N, 7)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                b_on = 1; b_bogus = 1;
            end else if (bq.size() > 0 && $urandom_range(0, 99) < b_pct) begin
                b_cur = {bq[0], ($urandom_range(0, 99) < 15) ? 2'b10 : 2'b00};
                b_on = 1; b_bogus = 0;
            end
        end
        l2_bvalid = b_on;
        l2_b      = b_cur;
    endtask

    initial begin
        int g, h, t;
        bit found, elig, exp_awv, exp_wv, in_rng, exp_bready, aw_hs, w_hs, b_hs, under;
        logic [N-1:0] exp_awr, exp_wr, exp_bv;
        logic [72:0] beat;

        rst = 1'b0;
        drive_idle();
        clear_all();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #2 reset_checks();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc == NCYC / 2) begin
                rst = 1'b0;
                clear_all();
                drive_idle();
                @(negedge clk);
                rst = 1'b1;
                #2 reset_checks();
                @(negedge clk);
            end
            drive_random(cyc);
            #2;

            // Expected behaviour from the arbitration, ordering and routing rules
            elig = (order.size() < D) && (outst < M);
            found = 0; g = 0;
            if (lock_vld) begin
                found = 1; g = lock_idx;
            end else begin
                for (int k = 0; k < N; k++)
                    if (!found && req_awvalid[(rr + k) % N]) begin
                        found = 1; g = (rr + k) % N;
                    end
            end
            exp_awv = elig && found;
            exp_awr = '0;
            if (exp_awv && l2_awready) exp_awr[g] = 1'b1;
            h = (order.size() > 0) ? order[0] : 0;
            exp_wv = (order.size() > 0) && req_wvalid[h];
            exp_wr = '0;
            if (order.size() > 0 && l2_wready) exp_wr[h] = 1'b1;
            t = int'(l2_b[8:6]);
            in_rng = (t < N);
            exp_bready = in_rng ? req_bready[t] : 1'b1;
            exp_bv = '0;
            if (l2_bvalid && in_rng) exp_bv[t] = 1'b1;

            chk("awvalid", l2_awvalid, exp_awv);
            if (exp_awv) chk("aw_payload", l2_aw, aw_q[g][0]);
            chk("awready", req_awready, exp_awr);
            chk("wvalid", l2_wvalid, exp_wv);
            if (exp_wv) chk("w_payload", l2_w, w_q[h][0]);
            chk("wready", req_wready, exp_wr);
            chk("bvalid", req_bvalid, exp_bv);
            chk("bready", l2_bready, exp_bready);
            chk("b_payload", req_b, l2_b);
            chk("err", err, err_m);

            // Advance the model by this cycle's handshakes
            aw_hs = exp_awv && l2_awready;
            w_hs  = exp_wv && l2_wready;
            b_hs  = l2_bvalid && exp_bready;
            if (aw_hs) lock_vld = 0;
            else if (exp_awv) begin lock_vld = 1; lock_idx = g; end
            if (w_hs) begin
                beat = w_q[h].pop_front();
                if (beat[8]) begin
                    void'(order.pop_front());
                    bq.push_back(beat[7:0]);
                end
            end
            if (aw_hs) begin
                order.push_back(g);
                rr = (g + 1) % N;
                void'(aw_q[g].pop_front());
                aw_on[g] = 0;
            end
            under = b_hs && !aw_hs && (outst == 0);
            outst = outst + (aw_hs ? 1 : 0) - ((b_hs && !under) ? 1 : 0);
`ifdef RVH_L1D_WB_ARB_BRESP_CHK_EN
            if (b_hs && ((l2_b[1:0] != 2'b00) || !in_rng || under)) err_m = 1;
`endif
            if (b_hs) begin
                b_on = 0;
                if (!b_bogus) void'(bq.pop_front());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
